// File: rtl/rs_seg_accum_if.sv
// rs_seg_accum_if: operand/result bundle for the segmented accumulator.
// The master drives operands and clear; the slave (the accumulator) returns
// the ready handshake, the committed value, the commit pulse and the sticky
// overflow flag.
interface rs_seg_accum_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             clear;
  logic [WIDTH-1:0] acc_out;
  logic             out_valid;
  logic             ovf;

  modport master (
    output in_valid,
    output in_data,
    output in_sub,
    output clear,
    input  in_ready,
    input  acc_out,
    input  out_valid,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sub,
    input  clear,
    output in_ready,
    output acc_out,
    output out_valid,
    output ovf
  );
endinterface : rs_seg_accum_if

// File: rtl/rs_seg_accum.sv
// rs_seg_accum: segmented multi-cycle accumulator.
// An accepted operand is added (or subtracted) one SEG_WIDTH slice per cycle
// into a shadow copy of the accumulator, with the inter-slice carry held in a
// flop so no physical carry chain exceeds SEG_WIDTH bits. The committed value
// acc_out only changes at commit, clear or reset, so consumers never see a
// partially updated sum.
// Optional feature macro: RS_ACC_SATURATE_EN -- when defined, an overflowing
// commit clamps to the most positive / most negative value instead of wrapping.
module rs_seg_accum #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  rs_seg_accum_if.slave   bus
);

  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SEGW-1:0] LAST_SEG = SEGW'(NSEG - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [SEGW-1:0]  seg_q,       seg_d;
  logic             cy_q,        cy_d;
  logic [WIDTH-1:0] opr_q,       opr_d;
  logic [WIDTH-1:0] shd_q,       shd_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;

  // Slice datapath signals
  logic [SEG_WIDTH-1:0] slice_a_s;
  logic [SEG_WIDTH-1:0] slice_b_s;
  logic [SEG_WIDTH:0]   slice_sum_s;
  logic [WIDTH-1:0]     shd_upd_s;
  logic                 a_sign_s;
  logic                 b_sign_s;
  logic                 r_sign_s;
  logic                 v_s;
  logic [WIDTH-1:0]     commit_s;

`ifdef RS_ACC_SATURATE_EN
  // Clamp value for an overflowing commit: both operands negative clamp to
  // the most negative value, both positive to the most positive value.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [WIDTH-1:0] val;
    if (neg) begin
      val = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      val = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return val;
  endfunction
`endif

  // One carry-chain slice: add the current segment of shadow and operand.
  always_comb begin
    int idx;
    idx         = int'(seg_q) * SEG_WIDTH;
    slice_a_s   = shd_q[idx +: SEG_WIDTH];
    slice_b_s   = opr_q[idx +: SEG_WIDTH];
    slice_sum_s = {1'b0, slice_a_s} + {1'b0, slice_b_s}
                + {{SEG_WIDTH{1'b0}}, cy_q};
    shd_upd_s   = shd_q;
    shd_upd_s[idx +: SEG_WIDTH] = slice_sum_s[SEG_WIDTH-1:0];
  end

  // Signed overflow of the full-width add, valid on the last segment where
  // the top slice of shd_q still holds the original accumulator sign.
  always_comb begin
    a_sign_s = shd_q[WIDTH-1];
    b_sign_s = opr_q[WIDTH-1];
    r_sign_s = slice_sum_s[SEG_WIDTH-1];
    v_s      = (a_sign_s == b_sign_s) && (r_sign_s != a_sign_s);
  end

  // Value to commit to acc_out at the end of an operation.
  always_comb begin
`ifdef RS_ACC_SATURATE_EN
    if (v_s) begin
      commit_s = sat_value(a_sign_s);
    end else begin
      commit_s = shd_upd_s;
    end
`else
    commit_s = shd_upd_s;
`endif
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    cy_d        = cy_q;
    opr_d       = opr_q;
    shd_d       = shd_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is acc + ~data + 1, the +1 entering as initial carry.
          if (bus.in_sub) begin
            opr_d = ~bus.in_data;
          end else begin
            opr_d = bus.in_data;
          end
          cy_d = bus.in_sub;
          if (bus.clear) begin
            shd_d = {WIDTH{1'b0}};
            ovf_d = 1'b0;
          end else begin
            shd_d = acc_q;
            ovf_d = ovf_q;
          end
          seg_d   = {SEGW{1'b0}};
          state_d = ST_RUN;
        end else if (bus.clear) begin
          acc_d = {WIDTH{1'b0}};
          ovf_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        shd_d = shd_upd_s;
        cy_d  = slice_sum_s[SEG_WIDTH];
        if (seg_q == LAST_SEG) begin
          // Final carry-out is discarded: arithmetic wraps modulo 2^WIDTH.
          acc_d       = commit_s;
          ovf_d       = ovf_q | v_s;
          out_valid_d = 1'b1;
          seg_d       = {SEGW{1'b0}};
          cy_d        = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          seg_d = seg_q + {{(SEGW-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d = ST_IDLE;
        seg_d   = {SEGW{1'b0}};
        cy_d    = 1'b0;
      end
    endcase

    if (state_d == ST_IDLE) begin
      in_ready_d = 1'b1;
    end else begin
      in_ready_d = 1'b0;
    end
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seg_q       <= {SEGW{1'b0}};
      cy_q        <= 1'b0;
      opr_q       <= {WIDTH{1'b0}};
      shd_q       <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      cy_q        <= cy_d;
      opr_q       <= opr_d;
      shd_q       <= shd_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.acc_out   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;

endmodule : rs_seg_accum
